// File: rtl/tft_console.sv
// tft_console: byte-stream terminal writer driving a COLS x ROWS TFT text memory write port.
// Define TFT_CONSOLE_CLEAR_ON_RESET_EN to blank the whole screen after reset release.
module tft_console #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [4:0]            cursor_row,
  output logic [6:0]            cursor_col,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ColsA    = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LastCell = ADDR_WIDTH'(ROWS * COLS - 1);
  localparam logic [6:0]            LastCol  = 7'(COLS - 1);
  localparam logic [4:0]            LastRow  = 5'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StClearLine, StClearScreen} state_e;

`ifdef TFT_CONSOLE_CLEAR_ON_RESET_EN
  localparam state_e ResetState = StClearScreen;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e                  state_q, state_d;
  logic [4:0]              row_q, row_d;
  logic [6:0]              col_q, col_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH-1:0]   clr_last_q, clr_last_d;

  logic                    accept;
  logic                    advance;
  logic [4:0]              next_row;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic [ADDR_WIDTH-1:0]   next_base;

  assign char_ready = (state_q == StIdle) && reset_n;
  assign accept     = char_valid && char_ready;
  assign next_row   = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
  assign row_base   = ADDR_WIDTH'(row_q) * ColsA;
  assign next_base  = ADDR_WIDTH'(next_row) * ColsA;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (char_data >= 8'h20 && char_data <= 8'h7e) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + ADDR_WIDTH'(col_q);
            wr_data_d = char_data;
            if (col_q == LastCol) begin
              col_d   = 7'd0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (char_data)
              8'h0d: col_d = 7'd0;
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d     = col_q - 7'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = row_base + ADDR_WIDTH'(col_q - 7'd1);
                  wr_data_d = BLANK_CHAR;
                end
              end
              8'h0a: begin
                col_d   = 7'd0;
                advance = 1'b1;
              end
              8'h0c: begin
                row_d      = 5'd0;
                col_d      = 7'd0;
                state_d    = StClearScreen;
                clr_addr_d = '0;
                clr_last_d = LastCell;
              end
              default: ;
            endcase
          end
          // No scrolling: the row wraps to the top and the new line is blanked.
          if (advance) begin
            row_d      = next_row;
            state_d    = StClearLine;
            clr_addr_d = next_base;
            clr_last_d = next_base + ColsA - ADDR_WIDTH'(1);
          end
        end
      end
      StClearLine, StClearScreen: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = BLANK_CHAR;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == clr_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ResetState;
      row_q      <= 5'd0;
      col_q      <= 7'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      clr_addr_q <= '0;
      clr_last_q <= LastCell;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tft_console.sv
// Bench for tft_console: directed scenarios plus random byte stream, checked against a
// cursor/write-list model of the terminal rules.
module tb_tft_console;
  localparam int COLS  = 80;
  localparam int ROWS  = 32;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'd0;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int m_row = 0;
  int m_col = 0;

  always #4 clk = ~clk;

  tft_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Terminal rules: returns the direct write (if any) and the blank run that follows.
  task automatic model(input logic [7:0] b, output bit cw, output int ca, output int cd,
                       output int cs, output int cl);
    bit adv = 0;
    cw = 0; ca = 0; cd = 0; cs = 0; cl = 0;
    if (b >= 8'h20 && b <= 8'h7e) begin
      cw = 1; ca = m_row * COLS + m_col; cd = b;
      if (m_col == COLS - 1) begin m_col = 0; adv = 1; end
      else m_col++;
    end else if (b == 8'h0d) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--; cw = 1; ca = m_row * COLS + m_col; cd = 8'h20;
      end
    end else if (b == 8'h0a) begin
      m_col = 0; adv = 1;
    end else if (b == 8'h0c) begin
      m_row = 0; m_col = 0; cs = 0; cl = CELLS;
    end
    if (adv) begin
      m_row = (m_row + 1) % ROWS;
      cs = m_row * COLS; cl = COLS;
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bit cw; int ca; int cd; int cs; int cl;
    while (char_ready !== 1'b1 && n < 3000) begin step(); n++; end
    chk("ready_before_send", 32'(char_ready), 1);
    if (n >= 3000) finish_now();
    model(b, cw, ca, cd, cs, cl);
    char_valid = 1'b1;
    char_data  = b;
    step();
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    chk("char_wr_en", 32'(wr_en), cw ? 1 : 0);
    if (cw) begin
      chk("char_wr_addr", 32'(wr_addr), ca);
      chk("char_wr_data", 32'(wr_data), cd);
    end
    if (cl > 0) begin
      chk("busy_on_clear_entry", 32'(busy), 1);
      chk("ready_low_on_clear_entry", 32'(char_ready), 0);
      for (int i = 0; i < cl; i++) begin
        step();
        chk("clr_wr_en", 32'(wr_en), 1);
        chk("clr_wr_addr", 32'(wr_addr), cs + i);
        chk("clr_wr_data", 32'(wr_data), 32'h20);
        chk("clr_char_ready", 32'(char_ready), (i == cl - 1) ? 1 : 0);
      end
    end
    chk("cursor_row", 32'(cursor_row), m_row);
    chk("cursor_col", 32'(cursor_col), m_col);
  endtask

  task automatic release_reset();
    #2 reset_n = 1'b1;
    m_row = 0;
    m_col = 0;
`ifdef TFT_CONSOLE_CLEAR_ON_RESET_EN
    #1 chk("ready_low_after_release", 32'(char_ready), 0);
    for (int i = 0; i < CELLS; i++) begin
      step();
      chk("reset_clr_wr_en", 32'(wr_en), 1);
      chk("reset_clr_addr", 32'(wr_addr), i);
      chk("reset_clr_data", 32'(wr_data), 32'h20);
      chk("reset_clr_ready", 32'(char_ready), (i == CELLS - 1) ? 1 : 0);
    end
`endif
  endtask

  function automatic logic [7:0] rand_byte();
    int p = int'($urandom_range(0, 99));
    if (p < 70) return 8'(32 + $urandom_range(0, 94));
    if (p < 78) return 8'h0d;
    if (p < 85) return 8'h08;
    if (p < 93) return 8'h0a;
    if (p < 94) return 8'h0c;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    // Reset state.
    step();
    step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(char_ready), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    release_reset();

    // "Hi" back to back.
    send(8'h48);
    send(8'h69);

    // Reach (3,79), then a wrapping 'Z'.
    send(8'h0d);
    repeat (3) send(8'h0a);
    repeat (79) send(8'(8'h21 + $urandom_range(0, 90)));
    send(8'h5a);

    // Reach (31,5), LF wraps to row 0.
    repeat (27) send(8'h0a);
    repeat (5) send(8'h2e);
    send(8'h0a);

    // Backspace at column 0, then after "AB".
    repeat (2) send(8'h0a);
    send(8'h08);
    send(8'h41);
    send(8'h42);
    send(8'h08);

    // Non-printable, non-control bytes.
    send(8'h07);
    send(8'h80);
    send(8'hff);

    // Full form feed.
    send(8'h0c);

    // Form feed interrupted by reset.
    send(8'h58);
    char_valid = 1'b1;
    char_data  = 8'h0c;
    step();
    char_valid = 1'b0;
    m_row = 0;
    m_col = 0;
    repeat (100) step();
    chk("mid_clear_addr", 32'(wr_addr), 99);
    chk("mid_clear_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_wr_addr", 32'(wr_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(char_ready), 0);
    chk("abort_row", 32'(cursor_row), 0);
    chk("abort_col", 32'(cursor_col), 0);
    release_reset();

    // Random stream with idle gaps; data is scrambled while valid is low.
    for (int k = 0; k < 600; k++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        char_data = 8'($urandom);
        step();
        chk("gap_wr_en", 32'(wr_en), 0);
      end
      send(rand_byte());
    end

    finish_now();
  end

endmodule
